// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared widths and state/op encodings for the L2 memory arbiter
package l2_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} arb_op_t;
endpackage

// File: rtl/l2_mem_arbiter_fsm.sv
// l2_mem_arbiter_fsm: locks the single L2 port to the I- or D-cache miss path for one transaction
module l2_mem_arbiter_fsm
  import l2_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pmem_addr_i,
  input  logic              pmem_read_i,
  input  logic [ADDR_W-1:0] pmem_addr_d,
  input  logic              pmem_read_d,
  input  logic              pmem_write_d,
  input  logic [LINE_W-1:0] pmem_wdata_d,
  input  logic              mem_resp_l2,
  input  logic [LINE_W-1:0] mem_rdata_l2,
  output logic              pmem_resp_i,
  output logic              pmem_resp_d,
  output logic [LINE_W-1:0] pmem_rdata_i,
  output logic [LINE_W-1:0] pmem_rdata_d,
  output logic              mem_read_l2,
  output logic              mem_write_l2,
  output logic [ADDR_W-1:0] mem_addr_l2,
  output logic [LINE_W-1:0] mem_wdata_l2
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  arb_state_t state, state_nxt;
  arb_op_t op_q, op_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [LINE_W-1:0] wdata_q, wdata_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic d_req, grant_d, grant_i, busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      op_q       <= op_nxt;
      addr_q     <= addr_nxt;
      wdata_q    <= wdata_nxt;
      starve_cnt <= starve_nxt;
    end
  end
  // D wins unless I has been passed over LIMIT times; a simultaneous D write beats D read
  always_comb begin
    d_req      = pmem_read_d | pmem_write_d;
    busy       = state != IDLE;
    grant_d    = !busy && d_req && (!pmem_read_i || starve_cnt < LIMIT);
    grant_i    = !busy && !grant_d && pmem_read_i;
    state_nxt  = grant_d ? SERVE_D : grant_i ? SERVE_I : (busy && mem_resp_l2) ? IDLE : state;
    addr_nxt   = grant_d ? pmem_addr_d : grant_i ? pmem_addr_i : addr_q;
    op_nxt     = grant_d ? (pmem_write_d ? OP_WRITE : OP_READ) : grant_i ? OP_READ : op_q;
    wdata_nxt  = (grant_d && pmem_write_d) ? pmem_wdata_d : (grant_d || grant_i) ? '0 : wdata_q;
    starve_nxt = grant_i ? '0 : (grant_d && pmem_read_i && starve_cnt < LIMIT) ? starve_cnt + 4'd1 : starve_cnt;
  end
  always_comb begin
    mem_read_l2  = busy && op_q == OP_READ;
    mem_write_l2 = busy && op_q == OP_WRITE;
    mem_addr_l2  = busy ? addr_q : '0;
    mem_wdata_l2 = mem_write_l2 ? wdata_q : '0;
    pmem_resp_i  = state == SERVE_I && mem_resp_l2;
    pmem_resp_d  = state == SERVE_D && mem_resp_l2;
    pmem_rdata_i = mem_rdata_l2;
    pmem_rdata_d = mem_rdata_l2;
  end
endmodule
